// File: rtl/tt_axil_lookup.sv
// tt_axil_lookup: times-table engine acting as an AXI4-Lite master in front of
// a single-port AXI4-Lite block memory.
//
// Optional fill phase (macro TT_INIT_EN): after reset the engine writes
// a*b for every operand pair, one AW/W/B transaction per entry.
// Without the macro, the memory is assumed preloaded and lookups start
// directly after reset.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready, a, b     lookup request (operands sampled on handshake)
//   rsp_valid/rsp_ready           lookup response handshake
//   result, rsp_err               product and |rresp, held while rsp_valid
//   init_done                     table available for lookups
//   m_axi_aw*/w*/b*               write channels (fill phase only)
//   m_axi_ar*/r*                  read channels (one read per lookup)
module tt_axil_lookup #(
  parameter int OP_W       = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ADDR_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_W-1:0]       a,
  input  logic [OP_W-1:0]       b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*OP_W-1:0]     result,
  output logic                  rsp_err,
  output logic                  init_done,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int IDX_W = 2 * OP_W;

  typedef enum logic [2:0] {S_INIT_W, S_INIT_B, S_IDLE, S_AR, S_R, S_RSP} state_t;
  state_t state;

`ifdef TT_INIT_EN
  logic [IDX_W-1:0] idx;
  logic             wr_issued;  // AW/W of the current entry have been raised
  logic [IDX_W-1:0] idx_prod;
  logic             unused_ok;

  // idx is {a,b}: upper half times lower half
  assign idx_prod    = IDX_W'(idx[IDX_W-1:OP_W]) * IDX_W'(idx[OP_W-1:0]);
  assign m_axi_wstrb = '1;
  assign unused_ok   = ^{m_axi_bresp, m_axi_rdata};
`else
  logic unused_ok;

  assign m_axi_awaddr  = '0;
  assign m_axi_awvalid = 1'b0;
  assign m_axi_wdata   = '0;
  assign m_axi_wstrb   = '0;
  assign m_axi_wvalid  = 1'b0;
  assign m_axi_bready  = 1'b0;
  assign unused_ok     = ^{m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid, m_axi_rdata};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef TT_INIT_EN
      state         <= S_INIT_W;
      idx           <= '0;
      wr_issued     <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
`else
      state         <= S_IDLE;
`endif
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      init_done     <= 1'b0;
      result        <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
`ifndef TT_INIT_EN
      init_done <= 1'b1;
`endif
      case (state)
`ifdef TT_INIT_EN
        S_INIT_W: begin
          if (!wr_issued) begin
            m_axi_awaddr  <= ADDR_W'(idx) << ADDR_SHIFT;
            m_axi_wdata   <= DATA_W'(idx_prod);
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            wr_issued     <= 1'b1;
          end else begin
            // each channel drops on its own handshake; move on once both are done
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
              wr_issued    <= 1'b0;
              m_axi_bready <= 1'b1;
              state        <= S_INIT_B;
            end
          end
        end
        S_INIT_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            idx          <= idx + 1'b1;
            if (idx == '1) begin
              init_done <= 1'b1;
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_INIT_W;
            end
          end
        end
`endif
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready     <= 1'b0;
            m_axi_araddr  <= ADDR_W'({a, b}) << ADDR_SHIFT;
            m_axi_arvalid <= 1'b1;
            state         <= S_AR;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            result       <= m_axi_rdata[IDX_W-1:0];
            rsp_err      <= |m_axi_rresp;
            rsp_valid    <= 1'b1;
            state        <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_axil_lookup.sv
`timescale 1ns/1ps
module tb_tt_axil_lookup;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  a = '0;
  logic [2:0]  b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [5:0]  result;
  logic        rsp_err, init_done;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_axil_lookup #(.OP_W(3), .ADDR_W(32), .DATA_W(32), .ADDR_SHIFT(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .a(a), .b(b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .result(result),
    .rsp_err(rsp_err), .init_done(init_done),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------- AXI4-Lite memory model ----------------
  int          ar_delay = 0;
  int          r_delay  = 0;
  bit          err_en   = 1'b0;
  logic [5:0]  err_idx  = '0;

  logic [31:0] mem [0:63];
  bit          preloaded = 1'b0;
  int          ar_cnt = 0, r_cnt = 0;
  bit          r_pend = 1'b0;
  logic [5:0]  r_idx = '0;
  bit          aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] w_addr = '0, w_dat = '0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, wr_cnt = 0;
  logic [31:0] log_addr [0:255];
  logic [31:0] log_data [0:255];

  assign awready = 1'b1;
  assign wready  = 1'b1;
  assign bresp   = 2'b00;
  assign arready = arvalid && (ar_cnt >= ar_delay);

  always @(posedge clk) begin
    if (rst) begin
      if (!preloaded) begin
        for (int i = 0; i < 64; i++)
`ifdef TT_INIT_EN
          mem[i] <= 32'hDEAD_0000 | i;
`else
          mem[i] <= (i >> 3) * (i & 7);
`endif
        preloaded <= 1'b1;
      end
      ar_cnt <= 0; r_pend <= 1'b0; r_cnt <= 0;
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0;
    end else begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_cnt <= 0;
        if (r_delay == 0) begin
          rvalid <= 1'b1;
          rdata  <= mem[araddr[5:0]];
          rresp  <= (err_en && araddr[5:0] == err_idx) ? 2'b10 : 2'b00;
        end else begin
          r_pend <= 1'b1; r_cnt <= 1; r_idx <= araddr[5:0];
        end
      end else if (arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (r_pend) begin
        if (r_cnt >= r_delay) begin
          r_pend <= 1'b0;
          rvalid <= 1'b1;
          rdata  <= mem[r_idx];
          rresp  <= (err_en && r_idx == err_idx) ? 2'b10 : 2'b00;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (awvalid && awready) begin aw_got <= 1'b1; w_addr <= awaddr; aw_hs <= aw_hs + 1; end
      if (wvalid && wready)   begin w_got <= 1'b1;  w_dat <= wdata;   w_hs <= w_hs + 1;   end
      if (bvalid && bready)   begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1;
        aw_got <= 1'b0; w_got <= 1'b0;
        mem[w_addr[5:0]] <= w_dat;
        if (wr_cnt < 256) begin
          log_addr[wr_cnt] <= w_addr;
          log_data[wr_cnt] <= w_dat;
        end
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  // Protocol monitor: a pending valid may not drop or change its payload
  int          proto_err = 0;
  bit          p_rst = 1'b1, p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_wv = 1'b0;
  logic [31:0] p_ara = '0, p_awa = '0, p_wd = '0;
  always @(posedge clk) begin
    if (!p_rst && ((p_arv && !p_arr && (!arvalid || araddr !== p_ara)) ||
                   (p_awv && !awready && (!awvalid || awaddr !== p_awa)) ||
                   (p_wv  && !wready  && (!wvalid  || wdata  !== p_wd))))
      proto_err <= proto_err + 1;
    p_rst <= rst; p_arv <= arvalid; p_arr <= arready; p_ara <= araddr;
    p_awv <= awvalid; p_awa <= awaddr; p_wv <= wvalid; p_wd <= wdata;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_req(input logic [2:0] ta, input logic [2:0] tb_, output bit ok);
    int n = 0;
    a = ta; b = tb_; req_valid = 1'b1;
    while (!req_ready && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    ok = (n < 3000);
  endtask

  task automatic wait_rsp(output bit ok, output int n);
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    ok = (n < 500);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin errors++; $display("FAIL reset_valids: got %b expected 00000", {awvalid, wvalid, arvalid, bready, rready}); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if ({rsp_valid, rsp_err} !== 2'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 00", {rsp_valid, rsp_err}); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    checks++; if (result !== 6'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++; if ({araddr, awaddr, wdata} !== 96'd0) begin errors++; $display("FAIL reset_addr_data: got %h %h %h expected 0", araddr, awaddr, wdata); end
  endtask

`ifdef TT_INIT_EN
  task automatic test_init();
    int n = 0, rr_bad = 0, late = 0, found = 0, bad25 = 0;
    a = 3'd7; b = 3'd6; req_valid = 1'b1;   // held during fill; must survive
    rst = 1'b0;
    while (!init_done && n < 3000) begin
      if (req_ready) rr_bad++;
      if (b_hs == 64) late++;
      @(negedge clk); n++;
    end
    checks++; if (n >= 3000) begin errors++; $display("FAIL init_timeout: got %0d cycles expected < 3000", n); end
    checks++; if (rr_bad != 0) begin errors++; $display("FAIL init_req_ready: got %0d cycles high expected 0", rr_bad); end
    checks++; if (late != 0) begin errors++; $display("FAIL init_done_late: got %0d cycles expected 0", late); end
    checks++; if (aw_hs != 64 || w_hs != 64) begin errors++; $display("FAIL init_aw_w_count: got %0d/%0d expected 64/64", aw_hs, w_hs); end
    checks++; if (b_hs != 64) begin errors++; $display("FAIL init_b_count: got %0d expected 64", b_hs); end
    for (int i = 0; i < wr_cnt && i < 256; i++)
      if (log_addr[i] == 32'h2D) begin found++; if (log_data[i] != 32'd25) bad25++; end
    checks++; if (found != 1 || bad25 != 0) begin errors++; $display("FAIL init_addr_2d: got %0d writes %0d bad expected 1 write data 25", found, bad25); end
    checks++; if (wstrb !== 4'hF) begin errors++; $display("FAIL init_wstrb: got %h expected f", wstrb); end
  endtask

  task automatic test_reset_mid_init();
    int n = 0, base, w0, a0, b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    base = b_hs;
    while (b_hs < base + 20 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n >= 2000) begin errors++; $display("FAIL midinit_reach20: got %0d B expected 20", b_hs - base); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, init_done} !== 6'b0) begin errors++; $display("FAIL midinit_reset_outputs: got %b expected 000000", {awvalid, wvalid, bready, arvalid, rready, init_done}); end
    w0 = wr_cnt; a0 = aw_hs; b0 = b_hs;
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    checks++; if (n >= 3000) begin errors++; $display("FAIL midinit_timeout: got %0d cycles expected < 3000", n); end
    checks++; if (log_addr[w0] !== 32'h0) begin errors++; $display("FAIL midinit_restart_addr: got %h expected 0", log_addr[w0]); end
    checks++; if (aw_hs - a0 != 64 || b_hs - b0 != 64 || wr_cnt - w0 != 64) begin errors++; $display("FAIL midinit_refill_count: got %0d/%0d/%0d expected 64", aw_hs - a0, b_hs - b0, wr_cnt - w0); end
  endtask

  task automatic test_log();
    int bad = 0;
    for (int i = 0; i < wr_cnt && i < 256; i++) begin
      int ea, eb;
      ea = log_addr[i][5:3]; eb = log_addr[i][2:0];
      if (log_addr[i][31:6] != 0 || log_data[i] != 32'(ea * eb)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL write_log_products: got %0d bad of %0d expected 0", bad, wr_cnt); end
  endtask
`else
  task automatic test_init();
    int n = 0;
    rst = 1'b0;
    while (!init_done && n < 100) begin @(negedge clk); n++; end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL preload_init_done: got %b expected 1", init_done); end
    checks++; if (aw_hs != 0 || awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin errors++; $display("FAIL preload_no_writes: got %0d writes expected 0", aw_hs); end
  endtask
`endif

  task automatic test_basic();
    bit ok; int n;
    send_req(3'd7, 3'd6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept: got timeout expected handshake"); end
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h3E) begin errors++; $display("FAIL basic_ar: got v=%b addr=%h expected v=1 addr=3e", arvalid, araddr); end
    wait_rsp(ok, n);
    checks++; if (!ok || n < 2) begin errors++; $display("FAIL basic_latency: got %0d cycles expected >= 2", n); end
    checks++; if (result !== 6'd42 || rsp_err !== 1'b0) begin errors++; $display("FAIL basic_result: got %0d err=%b expected 42 err=0", result, rsp_err); end
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || result !== 6'd42) begin errors++; $display("FAIL basic_hold: got v=%b %0d expected v=1 42", rsp_valid, result); end
    ack_rsp();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_delays();
    bit ok; int n, waits = 0, unstable = 0, pulses = 0;
    ar_delay = 3; r_delay = 2;
    send_req(3'd3, 3'd5, ok);
    while (!(arvalid && arready) && waits < 50) begin
      if (arvalid !== 1'b1 || araddr !== 32'h1D) unstable++;
      @(negedge clk); waits++;
    end
    checks++; if (unstable != 0 || waits != 3) begin errors++; $display("FAIL delay_ar_stable: got %0d unstable %0d waits expected 0 and 3", unstable, waits); end
    wait_rsp(ok, n);
    checks++; if (!ok || result !== 6'd15 || rsp_err !== 1'b0) begin errors++; $display("FAIL delay_result: got %0d err=%b expected 15 err=0", result, rsp_err); end
    ack_rsp();
    repeat (4) begin if (rsp_valid) pulses++; @(negedge clk); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL delay_single_rsp: got %0d extra cycles expected 0", pulses); end
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_rsp_hold();
    bit ok; int n, bad = 0;
    send_req(3'd4, 3'd6, ok);
    wait_rsp(ok, n);
    a = 3'd1; b = 3'd1; req_valid = 1'b1;  // must wait until the response is taken
    repeat (4) begin
      if (rsp_valid !== 1'b1 || result !== 6'd24 || rsp_err !== 1'b0 || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles expected 0 (result 24)", bad); end
    ack_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got v=%b rr=%b expected v=0 rr=1", rsp_valid, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h09) begin errors++; $display("FAIL hold_next_req: got v=%b addr=%h expected v=1 addr=09", arvalid, araddr); end
    wait_rsp(ok, n);
    checks++; if (!ok || result !== 6'd1) begin errors++; $display("FAIL hold_next_result: got %0d expected 1", result); end
    ack_rsp();
  endtask

  task automatic test_err();
    bit ok; int n;
    err_en = 1'b1; err_idx = 6'h12;
    send_req(3'd2, 3'd2, ok);
    wait_rsp(ok, n);
    checks++; if (!ok || rsp_err !== 1'b1 || result !== 6'd4) begin errors++; $display("FAIL err_resp: got err=%b %0d expected err=1 4", rsp_err, result); end
    ack_rsp();
    err_en = 1'b0;
  endtask

  task automatic test_corners();
    bit ok; int n;
    send_req(3'd0, 3'd0, ok);
    wait_rsp(ok, n);
    checks++; if (!ok || result !== 6'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL corner_0x0: got %0d err=%b expected 0 err=0", result, rsp_err); end
    ack_rsp();
    send_req(3'd7, 3'd7, ok);
    checks++; if (araddr !== 32'h3F) begin errors++; $display("FAIL corner_7x7_addr: got %h expected 3f", araddr); end
    wait_rsp(ok, n);
    checks++; if (!ok || result !== 6'd49 || rsp_err !== 1'b0) begin errors++; $display("FAIL corner_7x7: got %0d err=%b expected 49 err=0", result, rsp_err); end
    ack_rsp();
  endtask

  task automatic test_reset_mid_txn();
    bit ok; int n = 0;
    ar_delay = 20;
    send_req(3'd1, 3'd2, ok);
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h0A) begin errors++; $display("FAIL midtxn_ar: got v=%b addr=%h expected v=1 addr=0a", arvalid, araddr); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({arvalid, rready, req_ready, rsp_valid, init_done} !== 5'b0) begin errors++; $display("FAIL midtxn_reset: got %b expected 00000", {arvalid, rready, req_ready, rsp_valid, init_done}); end
    ar_delay = 0;
    rst = 1'b0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL midtxn_recover: got %b expected 1", init_done); end
  endtask

  task automatic test_after_reset();
    bit ok; int n;
    send_req(3'd5, 3'd5, ok);
    wait_rsp(ok, n);
    checks++; if (!ok || result !== 6'd25) begin errors++; $display("FAIL after_reset_5x5: got %0d expected 25", result); end
    ack_rsp();
    checks++; if (proto_err != 0) begin errors++; $display("FAIL axi_protocol: got %0d violations expected 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_delays();
    test_rsp_hold();
    test_err();
    test_corners();
    test_reset_mid_txn();
`ifdef TT_INIT_EN
    test_reset_mid_init();
    test_log();
`endif
    test_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
